// File: rtl/div_pkg.sv
// Shared definitions for the shift/subtract divider.
//   div_state_t       : controller state encoding (idle / running / done)
//   DIV_WIDTH_DEFAULT : default operand and result width in bits
package div_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRunning = 2'd1,
        StDone    = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_controller.sv
// Sequencing FSM and iteration counter for the restoring divider.
// Ports:
//   clk_i          : rising-edge clock
//   rst_i          : asynchronous active-high reset
//   start_i        : division request, honoured only in idle
//   divisor_zero_i : divisor presented with start_i is zero
//   load_o         : capture operands this edge (accepted start)
//   step_o         : perform one shift/subtract step this edge
//   last_o         : this step is the final one; publish results
//   busy_o         : running or done
//   ready_o        : one-cycle pulse while in done
module div_controller
    import div_pkg::*;
#(
    parameter int unsigned Width = DIV_WIDTH_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic divisor_zero_i,
    output logic load_o,
    output logic step_o,
    output logic last_o,
    output logic busy_o,
    output logic ready_o
);

    localparam int unsigned CntW = $clog2(Width + 1);

    div_state_t            state_q, state_d;
    logic      [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    cnt_d   = CntW'(Width);
                    // A zero divisor needs no iterations; results are fixed.
                    state_d = divisor_zero_i ? StDone : StRunning;
                end
            end
            StRunning: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        load_o  = 1'b0;
        step_o  = 1'b0;
        last_o  = 1'b0;
        busy_o  = 1'b0;
        ready_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                load_o = start_i;
            end
            StRunning: begin
                step_o = 1'b1;
                last_o = (cnt_q == CntW'(1));
                busy_o = 1'b1;
            end
            StDone: begin
                busy_o  = 1'b1;
                ready_o = 1'b1;
            end
            default: begin
                load_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_subtract_divider.sv
// Unsigned restoring divider producing one quotient bit per cycle, MSB first.
// Ports:
//   clk_in      : rising-edge clock
//   rst_in      : asynchronous active-high reset
//   start       : request a division (ignored while busy)
//   dividend    : numerator, sampled with start
//   divisor     : denominator, sampled with start
//   quotient    : registered result
//   remainder   : registered result
//   busy        : operation in progress or completing
//   ready       : one-cycle pulse, results valid
//   div_by_zero : last completed operation had a zero divisor
module shift_subtract_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             ready,
    output logic             div_by_zero
);

    logic load, step, last, divisor_zero;

    assign divisor_zero = (divisor == '0);

    div_controller #(
        .Width(WIDTH)
    ) u_ctrl (
        .clk_i         (clk_in),
        .rst_i         (rst_in),
        .start_i       (start),
        .divisor_zero_i(divisor_zero),
        .load_o        (load),
        .step_o        (step),
        .last_o        (last),
        .busy_o        (busy),
        .ready_o       (ready)
    );

    // dividend_q doubles as the quotient accumulator: dividend bits leave at
    // the MSB while quotient bits enter at the LSB.
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH+1:0] shifted, trial;
    logic [WIDTH:0]   rem_next;
    logic             take;

    // Restoring step; the extra top bit of trial acts as the borrow.
    always_comb begin
        shifted  = {rem_q, dividend_q[WIDTH-1]};
        trial    = shifted - {2'b00, divisor_q};
        take     = ~trial[WIDTH+1];
        rem_next = take ? trial[WIDTH:0] : shifted[WIDTH:0];
    end

    always_comb begin
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        if (load) begin
            dividend_d = dividend;
            divisor_d  = divisor;
            rem_d      = '0;
            dbz_d      = divisor_zero;
            if (divisor_zero) begin
                quotient_d  = '1;
                remainder_d = dividend;
            end
        end else if (step) begin
            rem_d      = rem_next;
            dividend_d = {dividend_q[WIDTH-2:0], take};
            if (last) begin
                quotient_d  = {dividend_q[WIDTH-2:0], take};
                remainder_d = rem_next[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dividend_q  <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_shift_subtract_divider.sv
module tb_shift_subtract_divider;

    localparam int unsigned W     = 8;
    localparam int unsigned NRAND = 300;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         ready;
    logic         div_by_zero;

    int unsigned checks = 0;
    int unsigned errors = 0;

    shift_subtract_divider #(
        .WIDTH(W)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .ready      (ready),
        .div_by_zero(div_by_zero)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick;
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    // One operation from idle; expected values come from plain arithmetic.
    task automatic run_op(input int unsigned a, input int unsigned b, input string tag);
        int unsigned lat, eq, er, ez, elat;
        if (b == 0) begin
            eq   = (1 << W) - 1;
            er   = a;
            ez   = 1;
            elat = 1;
        end else begin
            eq   = a / b;
            er   = a % b;
            ez   = 0;
            elat = W + 1;
        end
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        tick();
        start = 1'b0;
        lat   = 1;
        while (ready !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, lat, elat);
        check({tag, ".quotient"}, 32'(quotient), eq);
        check({tag, ".remainder"}, 32'(remainder), er);
        check({tag, ".dbz"}, 32'(div_by_zero), ez);
        check({tag, ".busy_done"}, 32'(busy), 1);
        tick();
        check({tag, ".ready_pulse"}, 32'(ready), 0);
        check({tag, ".busy_idle"}, 32'(busy), 0);
        check({tag, ".q_hold"}, 32'(quotient), eq);
        check({tag, ".dbz_hold"}, 32'(div_by_zero), ez);
    endtask

    initial begin
        int unsigned pulses;
        int unsigned c, next_acc, last_rdy, got, a, b, pa, pb;
        int unsigned qa[$];
        int unsigned qb[$];

        rst_in   = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk_in);
        check("rst.quotient", 32'(quotient), 0);
        check("rst.remainder", 32'(remainder), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.ready", 32'(ready), 0);
        check("rst.dbz", 32'(div_by_zero), 0);
        rst_in = 1'b0;

        // First edge after release with start high must be accepted.
        run_op(100, 7, "basic");
        run_op(5, 0, "div0");
        run_op(8, 2, "after_div0");
        run_op(255, 1, "max_by_1");
        run_op(3, 10, "small_by_big");
        run_op(255, 255, "max_by_max");
        run_op(0, 9, "zero_num");

        // Busy protection: start 200/3 then hammer start with 9/9.
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd3;
        tick();
        pulses = 0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (cyc <= 9) begin
                start    = 1'b1;
                dividend = 8'd9;
                divisor  = 8'd9;
            end else begin
                start = 1'b0;
            end
            check("busy.ready_timing", 32'(ready), (cyc == 9) ? 1 : 0);
            if (ready === 1'b1) begin
                pulses++;
                check("busy.quotient", 32'(quotient), 66);
                check("busy.remainder", 32'(remainder), 2);
            end
            tick();
        end
        check("busy.pulses", pulses, 1);
        check("busy.q_after", 32'(quotient), 66);
        check("busy.r_after", 32'(remainder), 2);
        check("busy.idle_after", 32'(busy), 0);

        // Reset mid-operation.
        start    = 1'b1;
        dividend = 8'd77;
        divisor  = 8'd5;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("rstmid.busy_before", 32'(busy), 1);
        rst_in = 1'b1;
        #1;
        check("rstmid.quotient", 32'(quotient), 0);
        check("rstmid.remainder", 32'(remainder), 0);
        check("rstmid.busy", 32'(busy), 0);
        check("rstmid.dbz", 32'(div_by_zero), 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            check("rstmid.no_ready", 32'(ready), 0);
        end
        rst_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("rstmid.no_ready_after", 32'(ready), 0);
        end
        run_op(77, 5, "after_rst");

        // Random regression, start held high, fresh operands every cycle.
        // With non-zero divisors operations are accepted every W+2 cycles,
        // starting at cycle 0.
        c        = 0;
        next_acc = 0;
        last_rdy = 0;
        got      = 0;
        start    = 1'b1;
        while (got < NRAND && c < NRAND * (W + 2) + 50) begin
            a        = $urandom_range(0, (1 << W) - 1);
            b        = $urandom_range(1, (1 << W) - 1);
            dividend = W'(a);
            divisor  = W'(b);
            if (ready === 1'b1) begin
                check("rand.spacing", c - last_rdy, (got == 0) ? W + 1 : W + 2);
                last_rdy = c;
                if (qa.size() == 0) begin
                    check("rand.unexpected_ready", 1, 0);
                end else begin
                    pa = qa.pop_front();
                    pb = qb.pop_front();
                    check("rand.quotient", 32'(quotient), pa / pb);
                    check("rand.remainder", 32'(remainder), pa % pb);
                    check("rand.identity", 32'(quotient) * pb + 32'(remainder), pa);
                    check("rand.rem_lt_div", (32'(remainder) < pb) ? 1 : 0, 1);
                end
                got++;
            end
            if (c == next_acc) begin
                qa.push_back(a);
                qb.push_back(b);
                next_acc += W + 2;
            end
            tick();
            c++;
        end
        check("rand.count", got, NRAND);
        start = 1'b0;
        repeat (W + 4) tick();
        check("end.idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
